// File: rtl/led_sequencer_if.sv
// Avalon-MM register bus of the LED sequencer.
// The master view belongs to the host, and the slave view belongs to the peripheral.
interface led_sequencer_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer with an Avalon-MM register file, a switch synchronizer and a level IRQ.
// Optional switch debounce is enabled by the macro LED_SEQ_DEBOUNCE_EN.
module led_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] PERIOD_RST      = 32'd25000000
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    led_sequencer_if.slave avs,
    input  logic [3:0]    sw_export,
    output logic [3:0]    ledr_export,
    output logic          irq
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_MIRROR = 2'd3;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic [1:0]  mode_q, mode_d;
    logic        enable_q, enable_d;
    logic        irqEn_q, irqEn_d;
    logic [3:0]  pattern_q, pattern_d;
    logic [31:0] period_q, period_d;
    logic        flag_q, flag_d;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  work_q, work_d;
    logic        phase_q, phase_d;
    logic [3:0]  ledr_q, ledr_d;

    logic [3:0]  sync1_q;
    logic [3:0]  swDb_q, swDb_d;

    logic        wrCtrl, wrPattern, wrPeriod, wrStatus, anyWrite;
    logic [31:0] periodLast;
    logic        tick;
    logic [31:0] rdMux;

    assign anyWrite  = avs.avs_write;
    assign wrCtrl    = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign wrPattern = avs.avs_write && (avs.avs_address == ADDR_PATTERN);
    assign wrPeriod  = avs.avs_write && (avs.avs_address == ADDR_PERIOD);
    assign wrStatus  = avs.avs_write && (avs.avs_address == ADDR_STATUS);

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam logic [31:0] DB_LIMIT = (DEBOUNCE_CYCLES < 1) ? 32'd1 : 32'(DEBOUNCE_CYCLES);

    logic [3:0]  sync2_q;
    logic [3:0]  cand_q, cand_d;
    logic [31:0] dbCnt_q, dbCnt_d;

    // A candidate value is accepted once it has been sampled DB_LIMIT times in a row.
    always_comb begin
        cand_d  = cand_q;
        dbCnt_d = dbCnt_q;
        swDb_d  = swDb_q;
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            dbCnt_d = 32'd1;
            if (DB_LIMIT == 32'd1) begin
                swDb_d = sync2_q;
            end
        end else begin
            if (dbCnt_q < DB_LIMIT) begin
                dbCnt_d = dbCnt_q + 32'd1;
            end
            if ((dbCnt_q + 32'd1) >= DB_LIMIT) begin
                swDb_d = sync2_q;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync2_q <= '0;
            cand_q  <= '0;
            dbCnt_q <= '0;
        end else begin
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            dbCnt_q <= dbCnt_d;
        end
    end
`else
    // Without debounce, swDb_q is itself the second synchronizer flop.
    always_comb begin
        swDb_d = sync1_q;
    end
`endif

    always_comb begin
        mode_d    = mode_q;
        enable_d  = enable_q;
        irqEn_d   = irqEn_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        flag_d    = flag_q;
        if (wrCtrl) begin
            mode_d   = avs.avs_writedata[1:0];
            enable_d = avs.avs_writedata[2];
            irqEn_d  = avs.avs_writedata[3];
        end
        if (wrPattern) begin
            pattern_d = avs.avs_writedata[3:0];
        end
        if (wrPeriod) begin
            period_d = avs.avs_writedata;
        end
        if (wrStatus && avs.avs_writedata[4]) begin
            flag_d = 1'b0;
        end
        // A switch change outranks a simultaneous clear of the change flag.
        if (swDb_d != swDb_q) begin
            flag_d = 1'b1;
        end
        irq_d = flag_q & irqEn_q;
    end

    always_comb begin
        rdMux = '0;
        unique case (avs.avs_address)
            ADDR_CTRL:    rdMux = {28'd0, irqEn_q, enable_q, mode_q};
            ADDR_PATTERN: rdMux = {28'd0, pattern_q};
            ADDR_PERIOD:  rdMux = period_q;
            ADDR_STATUS:  rdMux = {27'd0, flag_q, swDb_q};
            default:      rdMux = '0;
        endcase
        readdata_d = avs.avs_read ? rdMux : readdata_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        phase_d    = phase_q;
        ledr_d     = ledr_q;
        periodLast = (period_q == 32'd0) ? 32'd0 : (period_q - 32'd1);
        tick       = (state_q == RUN) && (cnt_q >= periodLast);

        unique case (state_q)
            OFF: begin
                cnt_d  = '0;
                ledr_d = '0;
            end
            LOAD: begin
                work_d  = pattern_q;
                cnt_d   = '0;
                phase_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = tick ? 32'd0 : (cnt_q + 32'd1);
                // A bus write in the tick cycle wins and the tick is dropped.
                if (tick && !anyWrite) begin
                    if (mode_q == MODE_BLINK) begin
                        phase_d = ~phase_q;
                    end
                    if (mode_q == MODE_CHASE) begin
                        work_d = {work_q[2:0], work_q[3]};
                    end
                end
                unique case (mode_q)
                    MODE_STATIC: ledr_d = pattern_q;
                    MODE_BLINK:  ledr_d = phase_q ? work_q : 4'd0;
                    MODE_CHASE:  ledr_d = work_q;
                    MODE_MIRROR: ledr_d = swDb_q;
                    default:     ledr_d = '0;
                endcase
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
                ledr_d  = '0;
            end
        endcase

        if (wrPeriod) begin
            cnt_d = '0;
        end
        if (wrCtrl) begin
            cnt_d   = '0;
            state_d = avs.avs_writedata[2] ? LOAD : OFF;
        end else if (wrPattern && enable_q) begin
            cnt_d   = '0;
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mode_q     <= '0;
            enable_q   <= 1'b0;
            irqEn_q    <= 1'b0;
            pattern_q  <= '0;
            period_q   <= PERIOD_RST;
            flag_q     <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            state_q    <= OFF;
            cnt_q      <= '0;
            work_q     <= '0;
            phase_q    <= 1'b0;
            ledr_q     <= '0;
            sync1_q    <= '0;
            swDb_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            enable_q   <= enable_d;
            irqEn_q    <= irqEn_d;
            pattern_q  <= pattern_d;
            period_q   <= period_d;
            flag_q     <= flag_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            phase_q    <= phase_d;
            ledr_q     <= ledr_d;
            sync1_q    <= sw_export;
            swDb_q     <= swDb_d;
        end
    end

    assign ledr_export      = ledr_q;
    assign irq              = irq_q;
    assign avs.avs_readdata = readdata_q;

endmodule
